// File: rtl/core2axi_arb_pkg.sv
// Shared types and constants for the core-to-AXI request arbiter.
package core2axi_arb_pkg;

  localparam int unsigned BE_WIDTH   = 4;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/core2axi_arbiter_if.sv
// Core-side requester bundle plus bridge-side request/response bundle.
interface core2axi_arbiter_if
  import core2axi_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [N_MASTERS-1:0]                  req_i;
  logic [N_MASTERS-1:0]                  gnt_o;
  logic [N_MASTERS-1:0]                  rvalid_o;
  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]  addr_i;
  logic [N_MASTERS-1:0]                  we_i;
  logic [N_MASTERS-1:0][BE_WIDTH-1:0]    be_i;
  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  wdata_i;
  logic [DATA_WIDTH-1:0]                 rdata_o;

  logic                                  data_req_o;
  logic                                  data_gnt_i;
  logic                                  data_rvalid_i;
  logic [ADDR_WIDTH-1:0]                 data_addr_o;
  logic                                  data_we_o;
  logic [BE_WIDTH-1:0]                   data_be_o;
  logic [DATA_WIDTH-1:0]                 data_wdata_o;
  logic [DATA_WIDTH-1:0]                 data_rdata_i;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
  );

endinterface

// File: rtl/core2axi_rr_sel.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module core2axi_rr_sel #(
  parameter int unsigned N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]         i_req,
  input  logic [$clog2(N_MASTERS)-1:0] i_ptr,
  output logic [$clog2(N_MASTERS)-1:0] o_idx,
  output logic                         o_valid
);

  localparam int unsigned IDX_W = $clog2(N_MASTERS);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % N_MASTERS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/core2axi_arbiter.sv
// Round-robin arbiter sharing one AXI bridge port among N_MASTERS core requesters.
module core2axi_arbiter
  import core2axi_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  core2axi_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W = $clog2(N_MASTERS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_MASTERS - 1);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_q;

  logic [IDX_W-1:0]      w_win;
  logic                  w_win_valid;
  logic [IDX_W-1:0]      w_sel;
  logic                  w_active;
  logic                  w_req;
  logic                  w_fire;
  logic [ADDR_WIDTH-1:0] w_addr;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == LAST) ? '0 : p + IDX_W'(1);
  endfunction

  core2axi_rr_sel #(
    .N_MASTERS (N_MASTERS)
  ) u_rr_sel (
    .i_req   (bus.req_i),
    .i_ptr   (rr_q),
    .o_idx   (w_win),
    .o_valid (w_win_valid)
  );

  // The selection cycle forwards the winner directly; afterwards only owner_q drives the bridge.
  always_comb begin
    w_sel    = (state_q == ST_IDLE) ? w_win : owner_q;
    w_active = ((state_q == ST_IDLE) && w_win_valid) || (state_q == ST_LOCK);
    w_req    = 1'b0;
    if (state_q == ST_IDLE)      w_req = w_win_valid;
    else if (state_q == ST_LOCK) w_req = bus.req_i[owner_q];
    w_fire   = w_req && bus.data_gnt_i;
    w_addr   = w_active ? bus.addr_i[w_sel] : '0;
  end

  always_comb begin
    bus.gnt_o        = '0;
    bus.rvalid_o     = '0;
    bus.rdata_o      = bus.data_rdata_i;
    bus.data_req_o   = w_req;
    bus.data_addr_o  = w_addr;
    bus.data_we_o    = 1'b0;
    bus.data_be_o    = '0;
    bus.data_wdata_o = '0;
    if (w_active) begin
      bus.data_we_o    = bus.we_i[w_sel];
      bus.data_be_o    = bus.be_i[w_sel];
      bus.data_wdata_o = bus.wdata_i[w_sel];
    end
    bus.gnt_o[w_sel] = w_fire;
    if ((state_q == ST_RESP) && bus.data_rvalid_i) begin
      bus.rvalid_o[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_win_valid) begin
            owner_q <= w_win;
            if (bus.data_gnt_i) begin
              rr_q    <= next_ptr(w_win);
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (w_fire) begin
            rr_q    <= next_ptr(owner_q);
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.data_rvalid_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // An owner must keep requesting until it has been granted.
  a_owner_holds_req: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_LOCK) |-> bus.req_i[owner_q]
  );

endmodule

// File: tb/tb_core2axi_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, random traffic vs reference model.
module tb_core2axi_arbiter;
  import core2axi_arb_pkg::*;

  // Three requesters so the round-robin wrap is exercised on a non-power-of-two count.
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  core2axi_arbiter_if #(.N_MASTERS(N), .ADDR_WIDTH(AW)) bus ();

  core2axi_arbiter #(
    .N_MASTERS  (N),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner (-1 when nobody holds the bridge), granted flag, next search start.
  int          m_owner;
  bit          m_granted;
  int          m_ptr;
  logic [N-1:0] m_gnt_last;

  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rv;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_eval();
    int              sel;
    int              c;
    logic [N-1:0]    e_gnt;
    logic [N-1:0]    e_rv;
    logic            e_req;
    logic [AW-1:0]   e_addr;
    logic            e_we;
    logic [3:0]      e_be;
    logic [31:0]     e_wd;
    @(negedge clk_i);
    sel = -1; e_gnt = '0; e_rv = '0; e_req = 1'b0;
    e_addr = '0; e_we = 1'b0; e_be = '0; e_wd = '0;
    if (!m_granted) begin
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (sel < 0 && bus.req_i[c]) sel = c;
        end
      end else begin
        sel = m_owner;
      end
    end
    if (sel >= 0) begin
      e_req  = bus.req_i[sel];
      e_addr = bus.addr_i[sel];
      e_we   = bus.we_i[sel];
      e_be   = bus.be_i[sel];
      e_wd   = bus.wdata_i[sel];
      if (e_req && bus.data_gnt_i) e_gnt[sel] = 1'b1;
    end
    if (m_granted && bus.data_rvalid_i) e_rv[m_owner] = 1'b1;
    chk("gnt_o", 64'(bus.gnt_o), 64'(e_gnt));
    chk("rvalid_o", 64'(bus.rvalid_o), 64'(e_rv));
    chk("data_req_o", 64'(bus.data_req_o), 64'(e_req));
    chk("data_addr_o", 64'(bus.data_addr_o), 64'(e_addr));
    chk("data_we_o", 64'(bus.data_we_o), 64'(e_we));
    chk("data_be_o", 64'(bus.data_be_o), 64'(e_be));
    chk("data_wdata_o", 64'(bus.data_wdata_o), 64'(e_wd));
    chk("rdata_o", 64'(bus.rdata_o), 64'(bus.data_rdata_i));
    m_gnt_last = e_gnt;
    if (!rst_ni) begin
      m_owner = -1; m_granted = 1'b0; m_ptr = 0;
    end else if (m_granted) begin
      if (bus.data_rvalid_i) begin m_owner = -1; m_granted = 1'b0; end
    end else if (sel >= 0) begin
      m_owner = sel;
      if (e_gnt != '0) begin m_granted = 1'b1; m_ptr = (sel + 1) % N; end
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic g, input logic rv, input logic [31:0] rd);
    bus.req_i = req; bus.data_gnt_i = g; bus.data_rvalid_i = rv; bus.data_rdata_i = rd;
  endtask

  initial begin
    int          cnt0;
    int          cnt1;
    logic [N-1:0] pend;

    rst_ni = 1'b0;
    bus.req_i = '0; bus.we_i = '0; bus.be_i = '0; bus.wdata_i = '0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = '0;
    bus.addr_i[0] = 32'h100; bus.addr_i[1] = 32'h200; bus.addr_i[2] = 32'h300;
    for (int m = 0; m < N; m++) bus.be_i[m] = 4'hF;
    m_owner = -1; m_granted = 1'b0; m_ptr = 0; m_gnt_last = '0;
    adv();

    //             rst   req     g     rv    rdata          e_gnt   e_rv    e_req e_addr
    tbl[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 3'b000, 1'b0, 1'b1, 32'h12345678, 3'b000, 3'b000, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 3'b011, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b1, 32'h100};
    tbl[3]  = '{1'b1, 3'b011, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b1, 32'h100};
    tbl[4]  = '{1'b1, 3'b011, 1'b1, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 32'h100};
    tbl[5]  = '{1'b1, 3'b010, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 3'b010, 1'b0, 1'b1, 32'hA0,       3'b000, 3'b001, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 3'b010, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b1, 32'h200};
    tbl[8]  = '{1'b1, 3'b010, 1'b1, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 32'h200};
    tbl[9]  = '{1'b1, 3'b000, 1'b0, 1'b1, 32'hB1,       3'b000, 3'b010, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      rst_ni = tbl[i].rst_n;
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      model_eval();
      chk($sformatf("tbl%0d_gnt", i), 64'(bus.gnt_o), 64'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_rvalid", i), 64'(bus.rvalid_o), 64'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_req", i), 64'(bus.data_req_o), 64'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i), 64'(bus.data_addr_o), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_rdata", i), 64'(bus.rdata_o), 64'(tbl[i].rdata));
      adv();
    end

    // Owner locked: master 0 arriving during LOCK must not steal the bridge.
    bus.addr_i[1] = 32'h40; bus.we_i[1] = 1'b1; bus.be_i[1] = 4'hF; bus.wdata_i[1] = 32'hDEADBEEF;
    drive(3'b010, 1'b0, 1'b0, 32'h0);
    model_eval(); chk("lock_sel_addr", 64'(bus.data_addr_o), 64'h40); adv();
    for (int i = 0; i < 2; i++) begin
      drive(3'b011, 1'b0, 1'b0, 32'h0);
      model_eval();
      chk("lock_addr", 64'(bus.data_addr_o), 64'h40);
      chk("lock_wdata", 64'(bus.data_wdata_o), 64'hDEADBEEF);
      chk("lock_we", 64'(bus.data_we_o), 64'h1);
      adv();
    end
    drive(3'b011, 1'b1, 1'b0, 32'h0);
    model_eval(); chk("lock_gnt", 64'(bus.gnt_o), 64'b010); adv();
    drive(3'b001, 1'b0, 1'b1, 32'h55);
    model_eval(); chk("lock_rvalid", 64'(bus.rvalid_o), 64'b010); adv();
    drive(3'b001, 1'b1, 1'b0, 32'h0);
    model_eval(); chk("wrap_gnt", 64'(bus.gnt_o), 64'b001); adv();

    // Reset while master 0 awaits its response.
    rst_ni = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    model_eval(); chk("rst_req", 64'(bus.data_req_o), 64'h0); adv();
    rst_ni = 1'b1;
    drive(3'b000, 1'b0, 1'b1, 32'h12345678);
    model_eval();
    chk("post_rst_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("post_rst_gnt", 64'(bus.gnt_o), 64'h0);
    chk("post_rst_addr", 64'(bus.data_addr_o), 64'h0);
    adv();

    // Continuous contention between masters 0 and 1 for 8 transactions.
    bus.addr_i[1] = 32'h200; bus.we_i[1] = 1'b0; bus.wdata_i[1] = '0;
    cnt0 = 0; cnt1 = 0;
    for (int t = 0; t < 8; t++) begin
      drive(3'b011, 1'b1, 1'b0, 32'h0);
      model_eval();
      chk($sformatf("rr_owner%0d", t), 64'(bus.gnt_o), (t % 2 == 0) ? 64'b001 : 64'b010);
      if (bus.gnt_o == 3'b001) cnt0++;
      if (bus.gnt_o == 3'b010) cnt1++;
      adv();
      drive(3'b011, 1'b0, 1'b1, 32'(t));
      model_eval();
      chk($sformatf("rr_rvalid%0d", t), 64'(bus.rvalid_o), (t % 2 == 0) ? 64'b001 : 64'b010);
      adv();
    end
    chk("rr_cnt0", 64'(cnt0), 64'd4);
    chk("rr_cnt1", 64'(cnt1), 64'd4);

    // Random traffic: requesters hold until granted, bridge grants/responds at random.
    pend = bus.req_i;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int m = 0; m < N; m++) begin
        if (m_gnt_last[m]) pend[m] = 1'b0;
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m]          = 1'b1;
          bus.addr_i[m]    = $urandom;
          bus.we_i[m]      = 1'($urandom_range(0, 1));
          bus.be_i[m]      = 4'($urandom);
          bus.wdata_i[m]   = $urandom;
        end
      end
      bus.req_i         = pend;
      bus.data_gnt_i    = 1'($urandom_range(0, 1));
      bus.data_rvalid_i = ($urandom_range(0, 2) == 0);
      bus.data_rdata_i  = $urandom;
      model_eval();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
